fp_significand_multiplier: RTL and testbench
============================================

Name: fp_significand_multiplier

Overview:
- Front end of the single-precision FPU multiplier datapath.
- Unpacks two IEEE-754 binary32 operands and restores the hidden bits.
- Forms the result sign and the biased exponent, and computes the 24x24 significand product with a sequential shift-add engine, one bit per cycle.
- Hands the upper 24 product bits plus the exponent to the downstream normalization stage over a valid/ready handshake.

Parameters:
- BIAS, 127, exponent bias subtracted from the sum of the two operand exponents.
- MANT_W, 24, significand width including the hidden bit. The block is only required to work at 24.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair a/b is valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  32  operand A, binary32.
- b  input  32  operand B, binary32.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  downstream accepts the result.
- fraction  output  24  product bits [47:24]; bit 23 has weight 2^1.
- exponent  output  8  biased result exponent.
- sign  output  1  a[31] XOR b[31].
- exp_overflow  output  1  biased exponent sum is 255 or more.
- exp_underflow  output  1  biased exponent sum is 0 or less.
- zero  output  1  either operand is zero or denormal (flushed).

Behaviour:
- Reset:
  - state = IDLE.
  - in_ready = 1, out_valid = 0.
  - fraction, exponent, sign, exp_overflow, exp_underflow, zero = 0.
  - Internal accumulator and counter cleared.
- Reset asserted mid-operation aborts it in the same edge. No partial result is ever presented.
- States: IDLE, MUL, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, capture the operands and do the following in that edge.
  - sign <= a[31] ^ b[31].
  - Compute e = {2'b0, ea} + {2'b0, eb} - BIAS as a 10-bit signed value.
  - ma = {1, a[22:0]}, mb = {1, b[22:0]}.
  - If ea == 0 or eb == 0: go to DONE with zero = 1, fraction = 0, exponent = 0, and both exponent flags = 0.
  - Otherwise: load multiplicand ma, multiplier register = mb, accumulator = 0, counter = 0; go to MUL.
- MUL:
  - in_ready = 0.
  - Each cycle: if multiplier[0], acc_hi(25-bit) += ma. Then shift {acc_hi, multiplier} right by one.
  - After 24 iterations (counter 0..23), the 48-bit product P sits in {acc_hi[23:0], multiplier}.
  - On counter == 23, go to DONE and register:
    - fraction = P[47:24];
    - exp_overflow = (e >= 255), exp_underflow = (e <= 0);
    - exponent = 8'hFF if overflow, 8'h00 if underflow, else e[7:0].
- DONE:
  - out_valid = 1 and in_ready = 0.
  - All outputs are held stable while out_ready = 0.
  - On out_ready, out_valid drops the next cycle and the state returns to IDLE. The next operand can be accepted one cycle after the handshake.
- Latency:
  - Nonzero operands: out_valid asserts 25 cycles after the accept edge (1 unpack cycle + 24 MUL cycles).
  - Zero path: out_valid asserts 1 cycle after the accept edge.
- Throughput: at most one operation in flight. There is no input buffering.
- in_valid while busy is ignored and the operands are not captured. The source must hold them until in_ready.
- Width rules:
  - The product is exact: no rounding, no truncation inside the block.
  - P[23:0] is discarded at the output.
  - Product range is [1,4), so fraction[23:22] is never 00 for nonzero operands.

Optional Feature:
- Macro: FPM_SPECIAL_OPERANDS_EN.
- Defined:
  - Adds output port special (1-bit).
  - If ea == 255 or eb == 255, the operation takes the 1-cycle path to DONE.
  - Result: exponent = 8'hFF, zero = 0, special = 1, and both exponent flags = 0.
  - fraction = 24'h000000 for infinity.
  - For a NaN input (exp 255, mantissa nonzero), or infinity times zero/denormal, fraction = 24'h400000.
  - Sign is still the XOR of the operand signs.
- Undefined:
  - No special port.
  - Exponent 255 is treated as an ordinary exponent and goes through MUL; it typically sets exp_overflow.

Test Plan:
- 1.0 x 1.0 (a = b = 32'h3F800000) -> after 25 cycles: fraction = 24'h400000, exponent = 127, sign = 0, all flags 0.
- 1.5 x 1.5 (a = b = 32'h3FC00000) -> fraction = 24'h900000, exponent = 127, sign = 0.
- -2.0 x 3.0 (a = 32'hC0000000, b = 32'h40400000) -> fraction = 24'h600000, exponent = 129, sign = 1.
- Zero: a = 32'h00000000, b = 32'h3F800000 -> out_valid 1 cycle after accept, zero = 1, fraction = 0, exponent = 0.
- Overflow: a = b = 32'h7F000000 -> exp_overflow = 1, exponent = 8'hFF. Underflow: a = b = 32'h00800000 -> exp_underflow = 1, exponent = 8'h00.
- Backpressure and reset:
  - Hold out_ready = 0 for 10 cycles in DONE -> outputs stable, in_ready = 0, a new in_valid is not captured.
  - Assert rst at MUL cycle 10 -> next cycle IDLE, in_ready = 1, out_valid = 0, all outputs 0.

Source files
------------

// File: rtl/fp_significand_multiplier.sv
// fp_significand_multiplier: binary32 unpack, sign/exponent and sequential 24x24 significand product.
// Optional FPM_SPECIAL_OPERANDS_EN adds the special port and Inf/NaN fast path.
module fp_significand_multiplier #(
   parameter int BIAS   = 127,
   parameter int MANT_W = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       a,
   input  logic [31:0]       b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [MANT_W-1:0] fraction,
   output logic [7:0]        exponent,
   output logic              sign,
   output logic              exp_overflow,
   output logic              exp_underflow,
   output logic              zero
`ifdef FPM_SPECIAL_OPERANDS_EN
   ,
   output logic              special
`endif
);
   localparam int CW = $clog2(MANT_W);
   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
   state_t state;
   logic [7:0] ea, eb;
   logic signed [9:0] e_n, e_q;
   logic [MANT_W-1:0] mcand, mplier;
   logic [MANT_W:0] acc, sum;
   logic [CW-1:0] cnt;
   logic ovf, unf;
   assign ea = a[30:23];
   assign eb = b[30:23];
   assign e_n = $signed({2'b0, ea} + {2'b0, eb} - 10'(BIAS));
   assign sum = acc + (mplier[0] ? {1'b0, mcand} : '0);
   assign ovf = e_q >= 10'sd255;
   assign unf = e_q <= 10'sd0;
   assign in_ready = state == IDLE;
`ifdef FPM_SPECIAL_OPERANDS_EN
   logic is_sp, sp_nan;
   assign is_sp = ea == 8'hFF || eb == 8'hFF;
   // NaN input, or infinity meeting a flushed zero, yields the canonical quiet pattern
   assign sp_nan = (ea == 8'hFF && a[22:0] != '0) || (eb == 8'hFF && b[22:0] != '0) || ea == 8'h00 || eb == 8'h00;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         out_valid <= 1'b0;
         fraction <= '0;
         exponent <= '0;
         sign <= 1'b0;
         exp_overflow <= 1'b0;
         exp_underflow <= 1'b0;
         zero <= 1'b0;
         e_q <= '0;
         mcand <= '0;
         mplier <= '0;
         acc <= '0;
         cnt <= '0;
`ifdef FPM_SPECIAL_OPERANDS_EN
         special <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               sign <= a[31] ^ b[31];
               e_q <= e_n;
               mcand <= {1'b1, a[MANT_W-2:0]};
               mplier <= {1'b1, b[MANT_W-2:0]};
               acc <= '0;
               cnt <= '0;
               zero <= 1'b0;
`ifdef FPM_SPECIAL_OPERANDS_EN
               special <= 1'b0;
               if (is_sp) begin
                  state <= DONE;
                  out_valid <= 1'b1;
                  special <= 1'b1;
                  exponent <= 8'hFF;
                  exp_overflow <= 1'b0;
                  exp_underflow <= 1'b0;
                  fraction <= sp_nan ? {2'b01, {(MANT_W-2){1'b0}}} : '0;
               end else
`endif
               if (ea == 8'h00 || eb == 8'h00) begin
                  state <= DONE;
                  out_valid <= 1'b1;
                  zero <= 1'b1;
                  fraction <= '0;
                  exponent <= '0;
                  exp_overflow <= 1'b0;
                  exp_underflow <= 1'b0;
               end else state <= MUL;
            end
            MUL: begin
               // {acc, mplier} shifts right one bit per cycle; the final shift is folded into sum[MANT_W:1]
               acc <= {1'b0, sum[MANT_W:1]};
               mplier <= {sum[0], mplier[MANT_W-1:1]};
               cnt <= cnt + 1'b1;
               if (cnt == CW'(MANT_W - 1)) begin
                  state <= DONE;
                  out_valid <= 1'b1;
                  fraction <= sum[MANT_W:1];
                  exp_overflow <= ovf;
                  exp_underflow <= unf;
                  exponent <= ovf ? 8'hFF : unf ? 8'h00 : e_q[7:0];
               end
            end
            DONE: if (out_ready) begin
               state <= IDLE;
               out_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_significand_multiplier.sv
// tb_fp_significand_multiplier: directed vectors for the significand multiplier front end.
module tb_fp_significand_multiplier;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic in_ready, out_valid, sign, exp_overflow, exp_underflow, zero;
   logic [31:0] a = '0, b = '0;
   logic [23:0] fraction;
   logic [7:0] exponent;
   int tests = 0, failed = 0, lat;
`ifdef FPM_SPECIAL_OPERANDS_EN
   logic special;
`endif
   always #5 clk = ~clk;
   fp_significand_multiplier dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .fraction(fraction), .exponent(exponent),
      .sign(sign), .exp_overflow(exp_overflow), .exp_underflow(exp_underflow), .zero(zero)
`ifdef FPM_SPECIAL_OPERANDS_EN
      , .special(special)
`endif
   );
   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      tests++;
      assert (o === e) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic start(input logic [31:0] va, input logic [31:0] vb);
      a = va;
      b = vb;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
   endtask
   task automatic finish_op();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("handshake_valid_drop", {31'b0, out_valid}, 32'd0);
   endtask
   task automatic res(input string tag, input int l, input logic [23:0] f, input logic [7:0] e,
                      input logic s, input logic ov, input logic un, input logic z);
      chk({tag, "_lat"}, lat, l);
      chk({tag, "_frac"}, {8'b0, fraction}, {8'b0, f});
      chk({tag, "_exp"}, {24'b0, exponent}, {24'b0, e});
      chk({tag, "_flags"}, {28'b0, sign, exp_overflow, exp_underflow, zero}, {28'b0, s, ov, un, z});
      chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
   endtask
   initial begin
      repeat (3) tick();
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_outs", {fraction, exponent}, 32'd0);
      chk("rst_flags", {28'b0, sign, exp_overflow, exp_underflow, zero}, 32'd0);
      rst = 1'b0;
      tick();
      start(32'h3F800000, 32'h3F800000);
      res("one_x_one", 25, 24'h400000, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0);
      finish_op();
      start(32'h3FC00000, 32'h3FC00000);
      res("1p5_sq", 25, 24'h900000, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0);
      // backpressure: outputs frozen and a new operand ignored
      in_valid = 1'b1;
      a = 32'h40400000;
      b = 32'h40400000;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_hold", {fraction, exponent}, {24'h900000, 8'd127});
         chk("bp_ctrl", {30'b0, out_valid, in_ready}, 32'd2);
      end
      in_valid = 1'b0;
      finish_op();
      chk("bp_in_ready_after", {31'b0, in_ready}, 32'd1);
      chk("bp_not_captured", {fraction, exponent}, {24'h900000, 8'd127});
      start(32'hC0000000, 32'h40400000);
      res("m2_x_3", 25, 24'h600000, 8'd129, 1'b1, 1'b0, 1'b0, 1'b0);
      finish_op();
      start(32'h3FFFFFFF, 32'h3F800000);
      res("allones_x_one", 25, 24'h7FFFFF, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0);
      finish_op();
      start(32'h00000000, 32'h3F800000);
      res("zero", 1, 24'h000000, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      finish_op();
      start(32'h7F000000, 32'h7F000000);
      res("overflow", 25, 24'h400000, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
      finish_op();
      start(32'h00800000, 32'h00800000);
      res("underflow", 25, 24'h400000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      finish_op();
`ifdef FPM_SPECIAL_OPERANDS_EN
      start(32'h7F800000, 32'hBF800000);
      res("inf", 1, 24'h000000, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("inf_special", {31'b0, special}, 32'd1);
      finish_op();
      start(32'h7F800000, 32'h00000000);
      res("inf_x_zero", 1, 24'h400000, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
      finish_op();
`endif
      // abort a multiply at MUL cycle 10 with reset
      a = 32'hC0000000;
      b = 32'h40400000;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (10) tick();
      chk("mid_busy", {31'b0, in_ready}, 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_ctrl", {30'b0, out_valid, in_ready}, 32'd1);
      chk("abort_outs", {fraction, exponent}, 32'd0);
      chk("abort_flags", {28'b0, sign, exp_overflow, exp_underflow, zero}, 32'd0);
      start(32'h3FC00000, 32'h3F800000);
      res("after_abort", 25, 24'h600000, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0);
      finish_op();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
